// File: rtl/i2c_bridge_pkg.sv
// i2c_bridge_pkg: shared types and helpers for the Wishbone-to-I2C register bridge.
// Holds the bridge FSM encoding, the register width and the address range check.
package i2c_bridge_pkg;

   localparam int REG_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE,
      STROBE,
      RESP
   } bridge_state_t;

   function automatic logic in_range(input int adr, input int regs);
      return adr < regs;
   endfunction

endpackage

// File: rtl/i2c_register_interface.sv
// i2c_register_interface: register-file side of the I2C master.
// The bridge drives strobes and write data; the register file returns data_out.
interface i2c_register_interface #(
   parameter int REGS         = 9,
   parameter int POWEROF2REGS = $clog2(REGS)**2
);

   logic                                              clk;
   logic                                              reset;
   logic [i2c_bridge_pkg::REG_WIDTH-1:0]              data_in;
   logic [POWEROF2REGS-1:0][i2c_bridge_pkg::REG_WIDTH-1:0] data_out;
   logic [POWEROF2REGS-1:0]                           write_en;
   logic [POWEROF2REGS-1:0]                           read_en;

   modport out (
      output clk,
      output reset,
      output data_in,
      output write_en,
      output read_en,
      input  data_out
   );

   modport in (
      input  clk,
      input  reset,
      input  data_in,
      input  write_en,
      input  read_en,
      output data_out
   );

endinterface

// File: rtl/i2c_reg_strobe_decoder.sv
// i2c_reg_strobe_decoder: word address plus enable to a one-hot strobe vector.
// Entries at or above REGS never assert, so unmapped addresses yield all-zero.
module i2c_reg_strobe_decoder
   import i2c_bridge_pkg::*;
#(
   parameter int REGS         = 9,
   parameter int POWEROF2REGS = $clog2(REGS)**2,
   parameter int ADDRESSWIDTH = $clog2(REGS)
) (
   input  logic                    en_i,
   input  logic [ADDRESSWIDTH-1:0] adr_i,
   output logic [POWEROF2REGS-1:0] strobe_o
);

   always_comb begin
      strobe_o = '0;
      for (int i = 0; i < POWEROF2REGS; i++) begin
         strobe_o[i] = en_i && in_range(i, REGS) && (int'(adr_i) == i);
      end
   end

endmodule

// File: rtl/i2c_wb_register_bridge.sv
// i2c_wb_register_bridge: Wishbone classic slave fronting the I2C register file.
// Define I2C_BUS_ERROR_EN to end unmapped accesses with wb_err_o instead of wb_ack_o.
module i2c_wb_register_bridge
   import i2c_bridge_pkg::*;
#(
   parameter int REGS         = 9,
   parameter int POWEROF2REGS = $clog2(REGS)**2,
   parameter int ADDRESSWIDTH = $clog2(REGS)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wb_cyc_i,
   input  logic                    wb_stb_i,
   input  logic                    wb_we_i,
   input  logic [ADDRESSWIDTH-1:0] wb_adr_i,
   input  logic [REG_WIDTH-1:0]    wb_dat_i,
   output logic [REG_WIDTH-1:0]    wb_dat_o,
   output logic                    wb_ack_o,
   output logic                    wb_err_o,
   i2c_register_interface.out      regs
);

   bridge_state_t           state_q;
   logic [ADDRESSWIDTH-1:0] adr_q;
   logic                    we_q;
   logic                    mapped_q;
   logic [REG_WIDTH-1:0]    din_q;
   logic [REG_WIDTH-1:0]    rd_q;
   logic [REG_WIDTH-1:0]    last_q;
   logic [POWEROF2REGS-1:0] wen_q;
   logic [POWEROF2REGS-1:0] ren_q;

   logic [POWEROF2REGS-1:0] wen_d;
   logic [POWEROF2REGS-1:0] ren_d;
   logic [REG_WIDTH-1:0]    rd_d;
   logic                    mapped_d;
   logic                    accept;
   logic                    resp_live;

   assign accept    = (state_q == IDLE) && wb_cyc_i && wb_stb_i;
   assign mapped_d  = in_range(int'(wb_adr_i), REGS);
   assign resp_live = (state_q == RESP) && wb_cyc_i;

   i2c_reg_strobe_decoder #(
      .REGS         (REGS),
      .POWEROF2REGS (POWEROF2REGS),
      .ADDRESSWIDTH (ADDRESSWIDTH)
   ) u_wr_dec (
      .en_i     (wb_we_i),
      .adr_i    (wb_adr_i),
      .strobe_o (wen_d)
   );

   i2c_reg_strobe_decoder #(
      .REGS         (REGS),
      .POWEROF2REGS (POWEROF2REGS),
      .ADDRESSWIDTH (ADDRESSWIDTH)
   ) u_rd_dec (
      .en_i     (!wb_we_i),
      .adr_i    (wb_adr_i),
      .strobe_o (ren_d)
   );

   always_comb begin
      rd_d = '0;
      if (!we_q && mapped_q) begin
         rd_d = regs.data_out[adr_q];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         adr_q    <= '0;
         we_q     <= 1'b0;
         mapped_q <= 1'b0;
         din_q    <= '0;
         rd_q     <= '0;
         last_q   <= '0;
         wen_q    <= '0;
         ren_q    <= '0;
      end else begin
         wen_q <= '0;
         ren_q <= '0;
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  adr_q    <= wb_adr_i;
                  we_q     <= wb_we_i;
                  mapped_q <= mapped_d;
                  din_q    <= wb_dat_i;
                  wen_q    <= wen_d;
                  ren_q    <= ren_d;
                  state_q  <= STROBE;
               end
            end
            STROBE: begin
               // Sampled before the register file applies any read side effect.
               rd_q    <= rd_d;
               state_q <= RESP;
            end
            RESP: begin
               if (wb_cyc_i) begin
                  last_q <= rd_q;
               end
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Ack follows cyc within RESP so a master that drops cyc gets no response.
`ifdef I2C_BUS_ERROR_EN
   assign wb_ack_o = resp_live && mapped_q;
   assign wb_err_o = resp_live && !mapped_q;
`else
   assign wb_ack_o = resp_live;
   assign wb_err_o = 1'b0;
`endif

   assign wb_dat_o = resp_live ? rd_q : last_q;

   assign regs.clk      = clk;
   assign regs.reset    = reset;
   assign regs.data_in  = din_q;
   assign regs.write_en = wen_q;
   assign regs.read_en  = ren_q;

endmodule

// File: tb/tb_i2c_wb_register_bridge.sv
// tb_i2c_wb_register_bridge: randomized self-checking bench for the register bridge.
// A simple register file sits on the interface; expectations come from a word-array model.
module tb_i2c_wb_register_bridge;

   localparam int REGS = 9;
   localparam int P    = $clog2(REGS)**2;
   localparam int AW   = $clog2(REGS);
`ifdef I2C_BUS_ERROR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic          clk   = 1'b0;
   logic          reset = 1'b1;
   logic          cyc   = 1'b0;
   logic          stb   = 1'b0;
   logic          we    = 1'b0;
   logic [AW-1:0] adr   = '0;
   logic [31:0]   dat_i = '0;
   logic [31:0]   dat_o;
   logic          ack;
   logic          err;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] model [REGS];
   logic [31:0] last_dat;
   logic [31:0] rf [P] = '{default: '0};

   i2c_register_interface #(.REGS(REGS)) rif ();

   i2c_wb_register_bridge #(.REGS(REGS)) dut (
      .clk      (clk),
      .reset    (reset),
      .wb_cyc_i (cyc),
      .wb_stb_i (stb),
      .wb_we_i  (we),
      .wb_adr_i (adr),
      .wb_dat_i (dat_i),
      .wb_dat_o (dat_o),
      .wb_ack_o (ack),
      .wb_err_o (err),
      .regs     (rif)
   );

   always #5 clk = ~clk;

   // Register file: mapped words hold written data, unmapped words hold junk.
   always_comb begin
      for (int i = 0; i < P; i++) begin
         if (i < REGS) rif.data_out[i] = rf[i];
         else          rif.data_out[i] = 32'hBAD0_0000 | 32'(i);
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < P; i++) begin
         if (rif.write_en[i]) rf[i] <= rif.data_in;
      end
   end

   function automatic logic [P-1:0] exp_strobe(input bit en, input int a);
      exp_strobe = '0;
      if (en && a < REGS) exp_strobe[a] = 1'b1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Plain bus access used to set up state; callers update the model.
   task automatic bus_access(input bit w, input int a, input logic [31:0] d);
      step(); cyc = 1'b1; stb = 1'b1; we = w; adr = AW'(a); dat_i = d;
      step(); stb = 1'b0;
      step();
      step(); cyc = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; cyc = 1'b0; stb = 1'b0;
      step();
      step();
      @(negedge clk);
      n_checks++;
      if (ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b want 0", ack); end
      n_checks++;
      if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
      n_checks++;
      if (dat_o !== 32'h0) begin n_fail++; $display("FAIL rst_dat: got %h want 0", dat_o); end
      n_checks++;
      if (rif.write_en !== '0) begin n_fail++; $display("FAIL rst_wen: got %h want 0", rif.write_en); end
      n_checks++;
      if (rif.read_en !== '0) begin n_fail++; $display("FAIL rst_ren: got %h want 0", rif.read_en); end
      n_checks++;
      if (rif.data_in !== 32'h0) begin n_fail++; $display("FAIL rst_din: got %h want 0", rif.data_in); end
      step(); reset = 1'b0;
      last_dat = '0;
      for (int i = 0; i < REGS; i++) model[i] = '0;
   endtask

   task automatic test_write();
      step(); cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 4'd3; dat_i = 32'hDEADBEEF;
      @(negedge clk);
      n_checks++;
      if (ack !== 1'b0) begin n_fail++; $display("FAIL wr_idle_ack: got %b want 0", ack); end
      step(); stb = 1'b0;
      @(negedge clk);
      n_checks++;
      if (rif.write_en !== exp_strobe(1'b1, 3)) begin
         n_fail++; $display("FAIL wr_wen: got %h want %h", rif.write_en, exp_strobe(1'b1, 3));
      end
      n_checks++;
      if (rif.read_en !== '0) begin n_fail++; $display("FAIL wr_ren: got %h want 0", rif.read_en); end
      n_checks++;
      if (rif.data_in !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL wr_din: got %h want deadbeef", rif.data_in);
      end
      model[3] = 32'hDEADBEEF;
      step();
      @(negedge clk);
      n_checks++;
      if (ack !== 1'b1) begin n_fail++; $display("FAIL wr_ack: got %b want 1", ack); end
      n_checks++;
      if (dat_o !== 32'h0) begin n_fail++; $display("FAIL wr_dat: got %h want 0", dat_o); end
      last_dat = '0;
      step(); cyc = 1'b0;
      @(negedge clk);
      n_checks++;
      if (ack !== 1'b0 || rif.write_en !== '0) begin
         n_fail++; $display("FAIL wr_after: got ack %b wen %h want 0 0", ack, rif.write_en);
      end
   endtask

   task automatic test_read();
      bus_access(1'b1, 5, 32'h12345678);
      model[5] = 32'h12345678;
      last_dat = '0;
      step(); cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 4'd5;
      step(); stb = 1'b0;
      @(negedge clk);
      n_checks++;
      if (rif.read_en !== exp_strobe(1'b1, 5)) begin
         n_fail++; $display("FAIL rd_ren: got %h want %h", rif.read_en, exp_strobe(1'b1, 5));
      end
      n_checks++;
      if (rif.write_en !== '0) begin n_fail++; $display("FAIL rd_wen: got %h want 0", rif.write_en); end
      step();
      @(negedge clk);
      n_checks++;
      if (ack !== 1'b1) begin n_fail++; $display("FAIL rd_ack: got %b want 1", ack); end
      n_checks++;
      if (dat_o !== model[5]) begin n_fail++; $display("FAIL rd_dat: got %h want %h", dat_o, model[5]); end
      last_dat = model[5];
      step(); cyc = 1'b0;
   endtask

   task automatic test_unmapped();
      step(); cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 4'd12;
      step(); stb = 1'b0;
      @(negedge clk);
      n_checks++;
      if (rif.read_en !== '0 || rif.write_en !== '0) begin
         n_fail++; $display("FAIL um_strobe: got ren %h wen %h want 0 0", rif.read_en, rif.write_en);
      end
      step();
      @(negedge clk);
      n_checks++;
      if (ack !== !ERR_EN) begin n_fail++; $display("FAIL um_ack: got %b want %b", ack, !ERR_EN); end
      n_checks++;
      if (err !== ERR_EN) begin n_fail++; $display("FAIL um_err: got %b want %b", err, ERR_EN); end
      n_checks++;
      if (dat_o !== 32'h0) begin n_fail++; $display("FAIL um_dat: got %h want 0", dat_o); end
      last_dat = '0;
      step(); cyc = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] d0, d1;
      d0 = $urandom;
      d1 = $urandom | 32'h1;
      bus_access(1'b1, 1, d1);
      model[1] = d1;
      step(); cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 4'd0; dat_i = d0;
      step();
      @(negedge clk);
      n_checks++;
      if (rif.write_en !== exp_strobe(1'b1, 0)) begin
         n_fail++; $display("FAIL b2b_wen: got %h want %h", rif.write_en, exp_strobe(1'b1, 0));
      end
      model[0] = d0;
      step(); we = 1'b0; adr = 4'd1;
      @(negedge clk);
      n_checks++;
      if (ack !== 1'b1 || dat_o !== 32'h0) begin
         n_fail++; $display("FAIL b2b_ack1: got ack %b dat %h want 1 0", ack, dat_o);
      end
      step();
      @(negedge clk);
      n_checks++;
      if (ack !== 1'b0 || rif.read_en !== '0 || rif.write_en !== '0) begin
         n_fail++; $display("FAIL b2b_gap: got ack %b ren %h wen %h want 0", ack, rif.read_en, rif.write_en);
      end
      step(); stb = 1'b0;
      @(negedge clk);
      n_checks++;
      if (rif.read_en !== exp_strobe(1'b1, 1)) begin
         n_fail++; $display("FAIL b2b_ren: got %h want %h", rif.read_en, exp_strobe(1'b1, 1));
      end
      step();
      @(negedge clk);
      n_checks++;
      if (ack !== 1'b1 || dat_o !== model[1]) begin
         n_fail++; $display("FAIL b2b_ack2: got ack %b dat %h want 1 %h", ack, dat_o, model[1]);
      end
      last_dat = model[1];
      step(); cyc = 1'b0;
   endtask

   task automatic test_reset_in_strobe();
      logic [31:0] d;
      d = $urandom;
      step(); cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 4'd4; dat_i = d;
      step(); reset = 1'b1; cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      n_checks++;
      if (rif.write_en !== exp_strobe(1'b1, 4)) begin
         n_fail++; $display("FAIL rs_wen: got %h want %h", rif.write_en, exp_strobe(1'b1, 4));
      end
      model[4] = d;
      step();
      @(negedge clk);
      n_checks++;
      if (rif.write_en !== '0 || rif.read_en !== '0) begin
         n_fail++; $display("FAIL rs_strobe: got wen %h ren %h want 0 0", rif.write_en, rif.read_en);
      end
      n_checks++;
      if (ack !== 1'b0) begin n_fail++; $display("FAIL rs_ack: got %b want 0", ack); end
      n_checks++;
      if (dat_o !== 32'h0) begin n_fail++; $display("FAIL rs_dat: got %h want 0", dat_o); end
      n_checks++;
      if (rif.data_in !== 32'h0) begin n_fail++; $display("FAIL rs_din: got %h want 0", rif.data_in); end
      last_dat = '0;
      step(); reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (ack !== 1'b0 || rif.write_en !== '0 || rif.read_en !== '0) begin
         n_fail++; $display("FAIL rs_idle: got ack %b wen %h ren %h want 0", ack, rif.write_en, rif.read_en);
      end
   endtask

   task automatic test_abort();
      logic [31:0] d2, d6;
      d2 = $urandom;
      d6 = $urandom;
      bus_access(1'b1, 2, d2);
      model[2] = d2;
      bus_access(1'b0, 3, 32'h0);
      last_dat = model[3];
      step(); cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 4'd2;
      step(); stb = 1'b0;
      @(negedge clk);
      n_checks++;
      if (rif.read_en !== exp_strobe(1'b1, 2)) begin
         n_fail++; $display("FAIL ab_ren: got %h want %h", rif.read_en, exp_strobe(1'b1, 2));
      end
      step(); cyc = 1'b0;
      @(negedge clk);
      n_checks++;
      if (ack !== 1'b0 || err !== 1'b0) begin
         n_fail++; $display("FAIL ab_ack: got ack %b err %b want 0 0", ack, err);
      end
      n_checks++;
      if (dat_o !== last_dat) begin n_fail++; $display("FAIL ab_dat: got %h want %h", dat_o, last_dat); end
      step(); cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 4'd6; dat_i = d6;
      step(); stb = 1'b0;
      @(negedge clk);
      n_checks++;
      if (rif.write_en !== exp_strobe(1'b1, 6)) begin
         n_fail++; $display("FAIL ab_next: got %h want %h", rif.write_en, exp_strobe(1'b1, 6));
      end
      model[6] = d6;
      step();
      step(); cyc = 1'b0;
      last_dat = '0;
   endtask

   task automatic test_random();
      bit          w, ab, mapped;
      int          a;
      logic [31:0] d, exp_dat;
      for (int n = 0; n < 60; n++) begin
         w  = 1'($urandom_range(0, 1));
         a  = $urandom_range(0, P - 1);
         d  = $urandom;
         ab = ($urandom_range(0, 3) == 0);
         mapped = (a < REGS);
         step(); cyc = 1'b1; stb = 1'b1; we = w; adr = AW'(a); dat_i = d;
         step(); stb = 1'b0;
         @(negedge clk);
         n_checks++;
         if (rif.write_en !== exp_strobe(w, a) || rif.read_en !== exp_strobe(!w, a)) begin
            n_fail++;
            $display("FAIL rnd_strobe[%0d]: got wen %h ren %h want %h %h", n,
                     rif.write_en, rif.read_en, exp_strobe(w, a), exp_strobe(!w, a));
         end
         n_checks++;
         if (rif.data_in !== d) begin n_fail++; $display("FAIL rnd_din[%0d]: got %h want %h", n, rif.data_in, d); end
         exp_dat = '0;
         if (!w && mapped) exp_dat = model[a];
         if (w && mapped) model[a] = d;
         step();
         if (ab) cyc = 1'b0;
         @(negedge clk);
         if (ab) exp_dat = last_dat;
         n_checks++;
         if (ack !== (!ab && (mapped || !ERR_EN)) || err !== (!ab && !mapped && ERR_EN)) begin
            n_fail++; $display("FAIL rnd_resp[%0d]: got ack %b err %b adr %0d abort %0b", n, ack, err, a, ab);
         end
         n_checks++;
         if (dat_o !== exp_dat) begin n_fail++; $display("FAIL rnd_dat[%0d]: got %h want %h", n, dat_o, exp_dat); end
         if (!ab) last_dat = exp_dat;
         step(); cyc = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_unmapped();
      test_back_to_back();
      test_reset_in_strobe();
      test_abort();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
